nibble_dot_mac: RTL and testbench

- Parametrised nibble-serial loader and sequential multiply-accumulate engine for pin-limited tiles.
- Two vectors, A (inputs) and B (weights), each DEPTH elements of DATA_W bits, are loaded NIB_W bits per cycle with auto-incrementing pointers.
- On start, the block computes sum(A[i]*B[i]) at one element per cycle and holds the result for the output mux.

---
 rtl/nibble_dot_mac.sv | 129 ++++++++++++
 tb/tb_nibble_dot_mac.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_dot_mac.sv
// Nibble-serial loader for two DATA_W-bit vectors followed by a sequential
// one-element-per-cycle multiply-accumulate that holds its last result.
module nibble_dot_mac #(
    parameter int DATA_W = 8,
    parameter int NIB_W  = 4,
    parameter int DEPTH  = 4,
    parameter int SIGNED = 0,
    parameter int ACC_W  = 2 * DATA_W + $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sel,
    input  logic [NIB_W-1:0] in_nibble,
    output logic             in_ready,
    input  logic             clr_ptr,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic [1:0]       state_dbg
);
    localparam int NPE   = DATA_W / NIB_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int K_W   = (NPE > 1) ? $clog2(NPE) : 1;
    localparam logic [K_W-1:0]   K_LAST   = K_W'(NPE - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  vec_a [DEPTH];
    logic [DATA_W-1:0]  vec_b [DEPTH];
    logic [PTR_W-1:0]   ptr_a, ptr_b, idx;
    logic [K_W-1:0]     k_a, k_b;
    logic [ACC_W-1:0]   acc, prod, acc_next;

    function automatic logic [ACC_W-1:0] ext(input logic [DATA_W-1:0] v);
        if (SIGNED != 0) return ACC_W'($signed(v));
        else             return ACC_W'(v);
    endfunction

    // Handshake: a nibble transfers on any clk edge where in_valid && in_ready;
    // in_ready depends only on state, start and clr_ptr, never on in_valid.
    assign in_ready  = (state == S_LOAD) && !start && !clr_ptr;
    assign state_dbg = state;

    // Product is taken at full accumulator width so wrap is modulo 2^ACC_W.
    always_comb begin
        prod     = ext(vec_a[idx]) * ext(vec_b[idx]);
        acc_next = acc + prod;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_LOAD;
            for (int i = 0; i < DEPTH; i++) begin
                vec_a[i] <= '0;
                vec_b[i] <= '0;
            end
            ptr_a  <= '0;
            ptr_b  <= '0;
            k_a    <= '0;
            k_b    <= '0;
            idx    <= '0;
            acc    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_LOAD: begin
                    if (start) begin
                        state <= S_COMPUTE;
                        busy  <= 1'b1;
                        acc   <= '0;
                        idx   <= '0;
                        ptr_a <= '0;
                        ptr_b <= '0;
                        k_a   <= '0;
                        k_b   <= '0;
                    end else if (clr_ptr) begin
                        ptr_a <= '0;
                        ptr_b <= '0;
                        k_a   <= '0;
                        k_b   <= '0;
                    end else if (in_valid) begin
                        if (in_sel) begin
                            vec_a[ptr_a][int'(k_a) * NIB_W +: NIB_W] <= in_nibble;
                            if (k_a == K_LAST) begin
                                k_a   <= '0;
                                ptr_a <= (ptr_a == PTR_LAST) ? '0 : ptr_a + 1'b1;
                            end else begin
                                k_a <= k_a + 1'b1;
                            end
                        end else begin
                            vec_b[ptr_b][int'(k_b) * NIB_W +: NIB_W] <= in_nibble;
                            if (k_b == K_LAST) begin
                                k_b   <= '0;
                                ptr_b <= (ptr_b == PTR_LAST) ? '0 : ptr_b + 1'b1;
                            end else begin
                                k_b <= k_b + 1'b1;
                            end
                        end
                    end
                end
                S_COMPUTE: begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                    if (idx == PTR_LAST) begin
                        // Result is published on the same edge so it is visible with done.
                        state  <= S_DONE;
                        result <= acc_next;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        idx    <= '0;
                    end
                end
                S_DONE:  state <= S_LOAD;
                default: state <= S_LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_dot_mac.sv
// Directed and randomized checks of nibble_dot_mac, unsigned and signed
// instances fed from the same stimulus, against an arithmetic vector model.
module tb_nibble_dot_mac;
    localparam int ACC_W = 18;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sel = 1'b0;
    logic [3:0]       in_nibble = '0;
    logic             clr_ptr = 1'b0;
    logic             start = 1'b0;

    logic             in_ready_u, busy_u, done_u;
    logic [ACC_W-1:0] result_u;
    logic [1:0]       st_u;
    logic             in_ready_s, busy_s, done_s;
    logic [ACC_W-1:0] result_s;
    logic [1:0]       st_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: vector contents and load pointers in plain integers.
    logic [7:0] ma [4];
    logic [7:0] mb [4];
    int pa, ka, pb, kb;

    always #5 clk = ~clk;

    nibble_dot_mac #(.DATA_W(8), .NIB_W(4), .DEPTH(4), .SIGNED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sel(in_sel),
        .in_nibble(in_nibble), .in_ready(in_ready_u), .clr_ptr(clr_ptr),
        .start(start), .busy(busy_u), .done(done_u), .result(result_u),
        .state_dbg(st_u)
    );

    nibble_dot_mac #(.DATA_W(8), .NIB_W(4), .DEPTH(4), .SIGNED(1)) u_sdut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sel(in_sel),
        .in_nibble(in_nibble), .in_ready(in_ready_s), .clr_ptr(clr_ptr),
        .start(start), .busy(busy_s), .done(done_s), .result(result_s),
        .state_dbg(st_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear_ptrs();
        pa = 0; ka = 0; pb = 0; kb = 0;
    endtask

    task automatic model_clear_all();
        for (int i = 0; i < 4; i++) begin
            ma[i] = 8'h00;
            mb[i] = 8'h00;
        end
        model_clear_ptrs();
    endtask

    task automatic model_write(input logic sel, input logic [3:0] nib);
        if (sel) begin
            ma[pa] = (ma[pa] & ~(8'h0F << (4 * ka))) | (8'(nib) << (4 * ka));
            ka++;
            if (ka == 2) begin ka = 0; pa = (pa + 1) % 4; end
        end else begin
            mb[pb] = (mb[pb] & ~(8'h0F << (4 * kb))) | (8'(nib) << (4 * kb));
            kb++;
            if (kb == 2) begin kb = 0; pb = (pb + 1) % 4; end
        end
    endtask

    function automatic logic [ACC_W-1:0] exp_dot(input bit sgn);
        longint s = 0;
        logic [63:0] t;
        for (int i = 0; i < 4; i++) begin
            if (sgn) s += longint'($signed(ma[i])) * longint'($signed(mb[i]));
            else     s += longint'(ma[i]) * longint'(mb[i]);
        end
        t = 64'(s);
        return t[ACC_W-1:0];
    endfunction

    task automatic send_nib(input logic sel, input logic [3:0] nib);
        in_valid  = 1'b1;
        in_sel    = sel;
        in_nibble = nib;
        #1;
        check("in_ready_load", 32'(in_ready_u), 32'd1);
        tick();
        in_valid = 1'b0;
        model_write(sel, nib);
    endtask

    task automatic load_elem(input logic sel, input logic [7:0] val);
        send_nib(sel, val[3:0]);
        send_nib(sel, val[7:4]);
    endtask

    task automatic pulse_clr(input bit with_nibble);
        clr_ptr   = 1'b1;
        in_valid  = with_nibble;
        in_sel    = 1'($urandom_range(0, 1));
        in_nibble = 4'($urandom_range(0, 15));
        #1;
        check("in_ready_clr", 32'(in_ready_u), 32'd0);
        tick();
        clr_ptr  = 1'b0;
        in_valid = 1'b0;
        model_clear_ptrs();
    endtask

    // Start a run and follow it cycle by cycle; noise drives ignored inputs in COMPUTE.
    task automatic run(input string tag, input bit noise);
        logic [ACC_W-1:0] eu, es;
        start = 1'b1;
        if (noise) begin
            in_valid  = 1'b1;
            in_sel    = 1'($urandom_range(0, 1));
            in_nibble = 4'($urandom_range(0, 15));
        end
        #1;
        check({tag, "_ready_at_start"}, 32'(in_ready_u), 32'd0);
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        model_clear_ptrs();
        eu = exp_dot(1'b0);
        es = exp_dot(1'b1);
        for (int c = 1; c <= 4; c++) begin
            if (noise) begin
                start     = 1'($urandom_range(0, 1));
                clr_ptr   = 1'($urandom_range(0, 1));
                in_valid  = 1'b1;
                in_sel    = 1'($urandom_range(0, 1));
                in_nibble = 4'($urandom_range(0, 15));
            end
            #1;
            check({tag, "_busy"}, 32'(busy_u), 32'd1);
            check({tag, "_done_early"}, 32'(done_u), 32'd0);
            check({tag, "_ready_compute"}, 32'(in_ready_u), 32'd0);
            tick();
        end
        start = 1'b0; clr_ptr = 1'b0; in_valid = 1'b0;
        check({tag, "_done"}, 32'(done_u), 32'd1);
        check({tag, "_busy_done"}, 32'(busy_u), 32'd0);
        check({tag, "_ready_done"}, 32'(in_ready_u), 32'd0);
        check({tag, "_result_u"}, 32'(result_u), 32'(eu));
        check({tag, "_result_s"}, 32'(result_s), 32'(es));
        check({tag, "_done_s"}, 32'(done_s), 32'd1);
        tick();
        check({tag, "_done_clear"}, 32'(done_u), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready_u), 32'd1);
        check({tag, "_result_hold"}, 32'(result_u), 32'(eu));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear_all();
        rst_n = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        check("rst_result_u", 32'(result_u), 32'd0);
        check("rst_result_s", 32'(result_s), 32'd0);
        check("rst_busy", 32'(busy_u), 32'd0);
        check("rst_done", 32'(done_u), 32'd0);
        check("rst_state", 32'(st_u), 32'd0);
        check("rst_ready", 32'(in_ready_u), 32'd1);

        // Basic: A={1,2,3,4}, B={5,6,7,8} -> 70
        for (int i = 0; i < 4; i++) load_elem(1'b1, 8'(i + 1));
        for (int i = 0; i < 4; i++) load_elem(1'b0, 8'(i + 5));
        check("basic_model", 32'(exp_dot(1'b0)), 32'd70);
        run("basic", 1'b0);

        // Maximum operands: no overflow in 18 bits
        for (int i = 0; i < 4; i++) begin
            load_elem(1'b1, 8'hFF);
            load_elem(1'b0, 8'hFF);
        end
        run("max", 1'b0);
        check("max_abs", 32'(result_u), 32'h3F804);

        // Signed corner: -1*2 + -128*127
        load_elem(1'b1, 8'hFF); load_elem(1'b1, 8'h80);
        load_elem(1'b1, 8'h00); load_elem(1'b1, 8'h00);
        load_elem(1'b0, 8'h02); load_elem(1'b0, 8'h7F);
        load_elem(1'b0, 8'h00); load_elem(1'b0, 8'h00);
        run("signed", 1'b0);
        check("signed_abs", 32'(result_s), 32'h3C07E);

        // Pointer wrap, then clr_ptr with a dropped nibble, then partial reload
        load_elem(1'b1, 8'd9); load_elem(1'b1, 8'd1); load_elem(1'b1, 8'd1);
        load_elem(1'b1, 8'd1); load_elem(1'b1, 8'd3);
        for (int i = 0; i < 4; i++) load_elem(1'b0, 8'd1);
        run("wrap", 1'b0);
        check("wrap_abs", 32'(result_u), 32'd6);
        load_elem(1'b1, 8'd7);
        pulse_clr(1'b1);
        load_elem(1'b1, 8'h10);
        run("clr", 1'b0);
        check("clr_abs", 32'(result_u), 32'd19);

        // Ignored inputs during start and COMPUTE; rerun must reproduce
        run("noise", 1'b1);
        run("rerun", 1'b0);

        // Randomized partial loads with interleaving and occasional clr_ptr
        for (int it = 0; it < 8; it++) begin
            int nn;
            nn = $urandom_range(0, 14);
            for (int j = 0; j < nn; j++) begin
                if ($urandom_range(0, 9) == 0) pulse_clr(1'($urandom_range(0, 1)));
                else send_nib(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            end
            run("rand", 1'(it % 2));
        end

        // Reset asserted in the second COMPUTE cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_clear_all();
        check("mid_rst_state", 32'(st_u), 32'd0);
        check("mid_rst_result", 32'(result_u), 32'd0);
        check("mid_rst_busy", 32'(busy_u), 32'd0);
        for (int c = 0; c < 6; c++) begin
            check("mid_rst_no_done", 32'(done_u | done_s), 32'd0);
            tick();
        end
        run("after_rst", 1'b0);
        check("after_rst_abs", 32'(result_u), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
